line_window_3x3: RTL

- Builds a sliding 3×3 pixel window from a raster pixel stream for the 2D FIR datapath.
- Sits directly upstream of the FIR multiply-accumulate stage and owns the two line memories.
- Writes each accepted pixel into a line RAM cascade and reads the two previous rows at the same column.
- Emits one 9-pixel window per accepted pixel whose row ≥ 2 and column ≥ 2 (valid-region output, no border padding).

---
 rtl/fir_pkg.sv | 25 ++
 rtl/line_window_3x3_if.sv | 31 +++
 rtl/line_window_3x3_line_ram.sv | 40 ++++
 rtl/line_window_3x3.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the 2D FIR front end: default geometry and the
// window tap numbering that both line_window_3x3 and the MAC stage use.
package fir_pkg;

    localparam int DEF_PIX_W     = 8;
    localparam int DEF_ADDR_W    = 11;
    localparam int DEF_IMG_WIDTH = 1920;

    localparam int WIN_ROWS   = 3;
    localparam int WIN_COLS   = 3;
    localparam int WIN_TAPS   = 9;
    localparam int WIN_CENTER = 4;
    localparam int WIN_NEWEST = 8;

    typedef logic [1:0] row_t;

    // Row counter saturates here; every row from the third one on is "full".
    localparam row_t ROW_FULL = 2'd2;

    // Tap number for row offset r (0 = two rows up) and column offset c (0 = two columns left).
    function automatic int win_idx(input int r, input int c);
        return WIN_COLS * r + c;
    endfunction

endpackage

// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out bundle between the raster source, the line window
// builder and the FIR MAC stage.
interface line_window_3x3_if
    import fir_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W
);

    logic                      in_valid;
    logic                      in_sof;
    logic [PIX_W-1:0]          in_data;
    logic                      win_valid;
    logic [WIN_TAPS*PIX_W-1:0] win;

    modport master (
        output in_valid,
        output in_sof,
        output in_data,
        input  win_valid,
        input  win
    );

    modport slave (
        input  in_valid,
        input  in_sof,
        input  in_data,
        output win_valid,
        output win
    );

endinterface

// File: rtl/line_window_3x3_line_ram.sv
// One line of pixel storage: single clock, one write and one read port,
// registered read that returns the pre-write contents on an address collision.
module line_ram
    import fir_pkg::*;
#(
    parameter int DATA_W = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_IMG_WIDTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // Contents are deliberately left unreset; the window gating never exposes stale data.
    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_window_3x3.sv
// Sliding 3x3 window builder: two cascaded line RAMs supply the rows above,
// a shift register forms the window, valid only inside the unpadded region.
module line_window_3x3
    import fir_pkg::*;
#(
    parameter int IMG_WIDTH = DEF_IMG_WIDTH,
    parameter int PIX_W     = DEF_PIX_W,
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    line_window_3x3_if.slave bus
);

    localparam int                WIN_W         = WIN_TAPS * PIX_W;
    localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_WIN_COL = ADDR_W'(2);

    logic              accept;
    logic [ADDR_W-1:0] pix_col;
    row_t              pix_row;

    logic [ADDR_W-1:0] col_q, col_d;
    row_t              row_q, row_d;

    logic              s1_valid_q, s1_valid_d;
    logic [PIX_W-1:0]  s1_pix_q, s1_pix_d;
    logic [ADDR_W-1:0] s1_col_q, s1_col_d;
    row_t              s1_row_q, s1_row_d;

    logic [WIN_W-1:0]  win_sh_q, win_sh_d;
    logic              s2_valid_q, s2_valid_d;

    logic              win_valid_q, win_valid_d;
    logic [WIN_W-1:0]  win_q, win_d;

    logic [PIX_W-1:0]  l0_rdata;
    logic [PIX_W-1:0]  l1_rdata;
    logic [PIX_W-1:0]  col_vec [WIN_ROWS];

    assign accept = bus.in_valid;

    // A start-of-frame pixel is placed at (0,0) no matter where the counters were.
    always_comb begin
        pix_col = bus.in_sof ? '0 : col_q;
        pix_row = bus.in_sof ? '0 : row_q;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pix_col == LAST_COL) begin
                col_d = '0;
                row_d = (pix_row == ROW_FULL) ? ROW_FULL : pix_row + 2'd1;
            end else begin
                col_d = pix_col + ADDR_W'(1);
                row_d = pix_row;
            end
        end
    end

    always_comb begin
        s1_valid_d = accept;
        s1_pix_d   = s1_pix_q;
        s1_col_d   = s1_col_q;
        s1_row_d   = s1_row_q;
        if (accept) begin
            s1_pix_d = bus.in_data;
            s1_col_d = pix_col;
            s1_row_d = pix_row;
        end
    end

    always_comb begin
        col_vec[0] = l1_rdata;
        col_vec[1] = l0_rdata;
        col_vec[2] = s1_pix_q;
    end

    // Window columns age left; the freshly read column vector enters at column 2.
    always_comb begin
        win_sh_d = win_sh_q;
        if (s1_valid_q) begin
            for (int r = 0; r < WIN_ROWS; r++) begin
                win_sh_d[PIX_W*win_idx(r, 0) +: PIX_W] = win_sh_q[PIX_W*win_idx(r, 1) +: PIX_W];
                win_sh_d[PIX_W*win_idx(r, 1) +: PIX_W] = win_sh_q[PIX_W*win_idx(r, 2) +: PIX_W];
                win_sh_d[PIX_W*win_idx(r, 2) +: PIX_W] = col_vec[r];
            end
        end
        s2_valid_d = s1_valid_q && (s1_row_q == ROW_FULL) && (s1_col_q >= FIRST_WIN_COL);
    end

    always_comb begin
        win_valid_d = s2_valid_q;
        win_d       = s2_valid_q ? win_sh_q : win_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_pix_q    <= '0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            win_sh_q    <= '0;
            s2_valid_q  <= 1'b0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            s1_valid_q  <= s1_valid_d;
            s1_pix_q    <= s1_pix_d;
            s1_col_q    <= s1_col_d;
            s1_row_q    <= s1_row_d;
            win_sh_q    <= win_sh_d;
            s2_valid_q  <= s2_valid_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    line_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (IMG_WIDTH)
    ) u_l0 (
        .clk   (clk),
        .we    (accept),
        .waddr (pix_col),
        .wdata (bus.in_data),
        .re    (accept),
        .raddr (pix_col),
        .rdata (l0_rdata)
    );

    // L1 receives what L0 held one row earlier, one cycle after the read.
    line_ram #(
        .DATA_W (PIX_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (IMG_WIDTH)
    ) u_l1 (
        .clk   (clk),
        .we    (s1_valid_q),
        .waddr (s1_col_q),
        .wdata (l0_rdata),
        .re    (accept),
        .raddr (pix_col),
        .rdata (l1_rdata)
    );

    assign bus.win_valid = win_valid_q;
    assign bus.win       = win_q;

endmodule
